// File: rtl/reset_sequencer.sv
// Staged reset release: hold every domain in reset, then free them in ascending order,
// waiting (with a timeout) for each domain's ready before a gap and the next release.
module reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_released,
    output logic                   timeout_err
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_WAIT    = 3'd2,
        S_GAP     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] r_domain_rst;
    logic                   r_all_released;
    logic                   r_sw_rst_ack;
    logic                   r_timeout_err;

    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [NUM_DOMAINS-1:0] w_rst_nxt;
    logic                   w_ack_nxt;
    logic                   w_tmo_nxt;
    logic [NUM_DOMAINS-1:0] w_idx_mask;
    logic                   w_ready_sel;

    // One-hot select avoids indexing by a possibly oversized idx when NUM_DOMAINS is 1.
    assign w_idx_mask  = NUM_DOMAINS'(1) << r_idx;
    assign w_ready_sel = |(domain_ready & w_idx_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_domain_rst;
        w_ack_nxt   = 1'b0;
        w_tmo_nxt   = r_timeout_err;
        case (r_state)
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                w_rst_nxt   = r_domain_rst & ~w_idx_mask;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A timeout is treated exactly like a ready so the sequence never stalls.
                if (w_ready_sel || (r_cnt == TMO_LAST)) begin
                    if (!w_ready_sel)
                        w_tmo_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_idx == IDX_LAST) ? S_DONE : S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_rst_nxt = '0;
                if (sw_rst_req) begin
                    w_rst_nxt   = '1;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_rst_nxt   = '1;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_HOLD;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_domain_rst   <= '1;
            r_all_released <= 1'b0;
            r_sw_rst_ack   <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_idx          <= w_idx_nxt;
            r_domain_rst   <= w_rst_nxt;
            r_all_released <= (w_state_nxt == S_DONE);
            r_sw_rst_ack   <= w_ack_nxt;
            r_timeout_err  <= w_tmo_nxt;
        end
    end

    assign domain_rst   = r_domain_rst;
    assign all_released = r_all_released;
    assign sw_rst_ack   = r_sw_rst_ack;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three instances cover ready-gated/sw-request
// sequencing, timeout stickiness, and the single-domain case.
module tb_reset_sequencer;

    logic       clock = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic       req_a, req_b, req_c;
    logic       ack_a, ack_b, ack_c;
    logic [3:0] rdy_a, rdy_b;
    logic [0:0] rdy_c;
    logic [3:0] drst_a, drst_b;
    logic [0:0] drst_c;
    logic       rel_a, rel_b, rel_c;
    logic       tmo_a, tmo_b, tmo_c;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) u_a (
        .clock(clock), .reset(rst_a), .sw_rst_req(req_a), .sw_rst_ack(ack_a),
        .domain_ready(rdy_a), .domain_rst(drst_a), .all_released(rel_a), .timeout_err(tmo_a));

    reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(8)) u_b (
        .clock(clock), .reset(rst_b), .sw_rst_req(req_b), .sw_rst_ack(ack_b),
        .domain_ready(rdy_b), .domain_rst(drst_b), .all_released(rel_b), .timeout_err(tmo_b));

    reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(2), .GAP_CYCLES(1), .TIMEOUT_CYCLES(4)) u_c (
        .clock(clock), .reset(rst_c), .sw_rst_req(req_c), .sw_rst_ack(ack_c),
        .domain_ready(rdy_c), .domain_rst(drst_c), .all_released(rel_c), .timeout_err(tmo_c));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        req_a = 0; req_b = 0; req_c = 0;
        rdy_a = 4'b1111; rdy_b = 4'b1011; rdy_c = 1'b1;

        // Reset values with reset held across an edge
        tick(1);
        chk("rst_drst", drst_a, 4'hF);
        chk("rst_rel",  rel_a,  0);
        chk("rst_ack",  ack_a,  0);
        chk("rst_tmo",  tmo_a,  0);

        // Release timing, ready tied high; edge numbers counted from reset release
        rst_a = 0;
        tick(4);  chk("a_e4_hold",  drst_a, 4'hF);
        tick(1);  chk("a_e5_d0",    drst_a, 4'hE);
        tick(3);  chk("a_e8",       drst_a, 4'hE);
        tick(1);  chk("a_e9_d1",    drst_a, 4'hC);
        tick(4);  chk("a_e13_d2",   drst_a, 4'h8);
        tick(4);  chk("a_e17_d3",   drst_a, 4'h0);
                  chk("a_e17_rel",  rel_a,  0);
        tick(1);  chk("a_e18_rel",  rel_a,  1);
                  chk("a_e18_tmo",  tmo_a,  0);
        tick(3);  chk("a_idle_rel", rel_a,  1);
                  chk("a_idle_ack", ack_a,  0);

        // Software request in DONE
        req_a = 1;
        tick(1);  chk("a_sw_ack",   ack_a,  1);
                  chk("a_sw_drst",  drst_a, 4'hF);
                  chk("a_sw_rel",   rel_a,  0);
        req_a = 0;
        tick(1);  chk("a_sw_ack1",  ack_a,  0);
        tick(3);  chk("a_sw_k4",    drst_a, 4'hF);
        tick(1);  chk("a_sw_k5",    drst_a, 4'hE);
        tick(12); chk("a_sw_k17",   drst_a, 4'h0);
                  chk("a_sw_k17r",  rel_a,  0);
        tick(1);  chk("a_sw_k18r",  rel_a,  1);

        // Async reset out of DONE, then ready-gated domain 1 and a request during GAP
        rdy_a = 4'b1101;
        rst_a = 1;
        #2;       chk("a_async_drst", drst_a, 4'hF);
                  chk("a_async_rel",  rel_a,  0);
        rst_a = 0;
        tick(6);  req_a = 1;
        tick(1);  chk("a_gap_ack7",  ack_a,  0);
        tick(1);  chk("a_gap_ack8",  ack_a,  0);
                  chk("a_gap_drst8", drst_a, 4'hE);
        tick(1);  chk("a_e9_d1b",    drst_a, 4'hC);
                  chk("a_e9_ack",    ack_a,  0);
        tick(10); chk("a_wait_e19",  drst_a, 4'hC);
                  chk("a_wait_tmo",  tmo_a,  0);
        rdy_a = 4'b1111;
        tick(3);  chk("a_rdy_e22",   drst_a, 4'hC);
        tick(1);  chk("a_rdy_e23",   drst_a, 4'h8);
        tick(4);  chk("a_e27",       drst_a, 4'h0);
                  chk("a_e27_rel",   rel_a,  0);
        tick(1);  chk("a_e28_rel",   rel_a,  1);
                  chk("a_e28_ack",   ack_a,  0);
        tick(1);  chk("a_e29_ack",   ack_a,  1);
                  chk("a_e29_drst",  drst_a, 4'hF);
                  chk("a_e29_rel",   rel_a,  0);
                  chk("a_e29_tmo",   tmo_a,  0);
        req_a = 0;

        // Reset while waiting on domain 2
        rdy_a = 4'b1011;
        tick(15); chk("a_w2_drst",   drst_a, 4'h8);
        rst_a = 1;
        #2;       chk("a_mid_drst",  drst_a, 4'hF);
                  chk("a_mid_rel",   rel_a,  0);
                  chk("a_mid_ack",   ack_a,  0);
                  chk("a_mid_tmo",   tmo_a,  0);
        rst_a = 0;
        rdy_a = 4'b1111;
        tick(4);  chk("a_rs_e4",     drst_a, 4'hF);
        tick(1);  chk("a_rs_e5",     drst_a, 4'hE);

        // Timeout on domain 2 with TIMEOUT_CYCLES=8
        rst_b = 0;
        tick(13); chk("b_e13",       drst_b, 4'h8);
        tick(7);  chk("b_e20_tmo",   tmo_b,  0);
        tick(1);  chk("b_e21_tmo",   tmo_b,  1);
                  chk("b_e21_drst",  drst_b, 4'h8);
        tick(3);  chk("b_e24_drst",  drst_b, 4'h0);
                  chk("b_e24_rel",   rel_b,  0);
        tick(1);  chk("b_e25_rel",   rel_b,  1);
        rdy_b = 4'b1111;
        req_b = 1;
        tick(1);  chk("b_sw_ack",    ack_b,  1);
                  chk("b_sw_tmo",    tmo_b,  1);
                  chk("b_sw_drst",   drst_b, 4'hF);
        req_b = 0;
        tick(18); chk("b_sw_rel",    rel_b,  1);
                  chk("b_sw_tmo2",   tmo_b,  1);
        rst_b = 1;
        #2;       chk("b_hw_tmo",    tmo_b,  0);
        rst_b = 0;

        // Single domain: WAIT goes straight to DONE
        rst_c = 0;
        tick(2);  chk("c_e2_drst",   drst_c, 1);
        tick(1);  chk("c_e3_drst",   drst_c, 0);
                  chk("c_e3_rel",    rel_c,  0);
        tick(1);  chk("c_e4_rel",    rel_c,  1);
                  chk("c_e4_tmo",    tmo_c,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
